f_sweep_ctrl: RTL and testbench

F_SWEEP_CTRL -- requirements
Module: f_sweep_ctrl

---
 rtl/f_sweep_pkg.sv | 18 +
 rtl/f_sweep_ctrl_settle_timer.sv | 32 +++
 rtl/f_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_f_sweep_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/f_sweep_pkg.sv
// Shared types and constants for the f truth-table sweep controller.
package f_sweep_pkg;

  localparam int NUM_VECTORS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Mismatch counter increment that stops at NUM_VECTORS.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= 5'(NUM_VECTORS)) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/f_sweep_ctrl_settle_timer.sv
// Settle delay: while enabled, raises expire on the SETTLE_CYCLES-th enabled cycle.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  assign expire = en && (cnt_r == LAST);

  // Cycle counter, cleared on load or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load || expire) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/f_sweep_ctrl.sv
// Drives all 16 input vectors into an external f instance, captures its
// output per vector and compares against a latched golden truth table.
module f_sweep_ctrl
  import f_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic        f_a,
  output logic        f_b,
  output logic        f_c,
  output logic        f_d,
  input  logic        f_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx
);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [15:0] exp_r, exp_s;
  logic [15:0] tt_r, tt_s;
  logic [4:0]  mc_r, mc_s;
  logic [3:0]  ffi_r, ffi_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        pass_r, pass_s;
  logic        expire_s;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_r != SETTLE),
    .en     (state_r == SETTLE),
    .expire (expire_s)
  );

  // Next-state and result update logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    exp_s   = exp_r;
    tt_s    = tt_r;
    mc_s    = mc_r;
    ffi_s   = ffi_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            exp_s   = expected;
            tt_s    = 16'h0000;
            mc_s    = 5'd0;
            ffi_s   = 4'd0;
            idx_s   = 4'd0;
            state_s = SETTLE;
          end else begin
            state_s = state_r;
          end
        end
        SETTLE: begin
          if (expire_s) begin
            state_s = SAMPLE;
          end else begin
            state_s = SETTLE;
          end
        end
        SAMPLE: begin
          tt_s[idx_r] = f_out;
          if (f_out != exp_r[idx_r]) begin
            mc_s = sat_inc(mc_r);
            if (mc_r == 5'd0) begin
              ffi_s = idx_r;
            end else begin
              ffi_s = ffi_r;
            end
          end else begin
            mc_s = mc_r;
          end
          if (idx_r == 4'(NUM_VECTORS - 1)) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r + 4'd1;
            state_s = SETTLE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s == SETTLE) || (state_s == SAMPLE);
    done_s = (state_s == DONE);
    pass_s = (state_s == DONE) && (mc_s == 5'd0);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      exp_r   <= 16'h0000;
      tt_r    <= 16'h0000;
      mc_r    <= 5'd0;
      ffi_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      exp_r   <= exp_s;
      tt_r    <= tt_s;
      mc_r    <= mc_s;
      ffi_r   <= ffi_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign {f_a, f_b, f_c, f_d} = idx_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign truth_table    = tt_r;
  assign mismatch_cnt   = mc_r;
  assign first_fail_idx = ffi_r;

endmodule

// File: tb/tb_f_sweep_ctrl.sv
// Self-checking bench: table-driven sweeps plus abort, reset and SETTLE_CYCLES=1 sequences.
module tb_f_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] expected;
  logic        f_a, f_b, f_c, f_d, f_out;
  logic        busy, done, pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic [15:0] model;

  logic        start1, abort1;
  logic [15:0] expected1;
  logic        f_a1, f_b1, f_c1, f_d1, f_out1;
  logic        busy1, done1, pass1;
  logic [15:0] truth_table1;
  logic [4:0]  mismatch_cnt1;
  logic [3:0]  first_fail_idx1;
  logic [15:0] model1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign f_out  = model[{f_a, f_b, f_c, f_d}];
  assign f_out1 = model1[{f_a1, f_b1, f_c1, f_d1}];

  f_sweep_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .f_a(f_a), .f_b(f_b), .f_c(f_c), .f_d(f_d), .f_out(f_out),
    .busy(busy), .done(done), .pass(pass), .truth_table(truth_table),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx)
  );

  f_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected1),
    .f_a(f_a1), .f_b(f_b1), .f_c(f_c1), .f_d(f_d1), .f_out(f_out1),
    .busy(busy1), .done(done1), .pass(pass1), .truth_table(truth_table1),
    .mismatch_cnt(mismatch_cnt1), .first_fail_idx(first_fail_idx1)
  );

  typedef struct {
    logic [15:0] exp_tab;
    logic [15:0] mdl;
    int          pulse_at;
    logic [15:0] want_tt;
    logic [4:0]  want_mc;
    logic [3:0]  want_ffi;
    logic        want_pass;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Runs one sweep on dut; returns edges from the accepting edge to done, and order errors.
  task automatic run_sweep(input logic [15:0] e, input int pulse_at, output int edges, output int order_err);
    expected = e;
    start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    order_err = 0;
    while (!done && edges < 1000) begin
      start = (edges == pulse_at);
      if ({f_a, f_b, f_c, f_d} != 4'(edges / 5) || !busy) order_err++;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
  endtask

  int edges, oerr, guard;

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, -1, 16'hA5C3, 5'd0, 4'd0, 1'b1};
    vecs[1] = '{16'hA5C3, 16'hA5C1 ^ 16'h0100, 37, 16'hA4C1, 5'd2, 4'd1, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, -1, 16'hFFFF, 5'd16, 4'd0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h7FFF, 12, 16'h7FFF, 5'd1, 4'd15, 1'b0};
    vecs[4] = '{16'h0001, 16'h0000, -1, 16'h0000, 5'd1, 4'd0, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, -1, 16'h1234, 5'd0, 4'd0, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 16'h0000; model = 16'h0000;
    start1 = 1'b0; abort1 = 1'b0; expected1 = 16'h0000; model1 = 16'h0000;
    #12;
    chk("reset_outputs", {f_a, f_b, f_c, f_d, busy, done, pass, truth_table, mismatch_cnt, first_fail_idx}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, done, pass}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      model = vecs[i].mdl;
      run_sweep(vecs[i].exp_tab, vecs[i].pulse_at, edges, oerr);
      chk($sformatf("v%0d_edges", i), 32'(edges), 32'd80);
      chk($sformatf("v%0d_order", i), 32'(oerr), 32'd0);
      chk($sformatf("v%0d_tt", i), {16'h0, truth_table}, {16'h0, vecs[i].want_tt});
      chk($sformatf("v%0d_mc", i), {27'h0, mismatch_cnt}, {27'h0, vecs[i].want_mc});
      chk($sformatf("v%0d_ffi", i), {28'h0, first_fail_idx}, {28'h0, vecs[i].want_ffi});
      chk($sformatf("v%0d_pass", i), {31'h0, pass}, {31'h0, vecs[i].want_pass});
    end

    // DONE holds results and f_* until the next start.
    repeat (6) @(posedge clk);
    #1;
    chk("done_hold", {done, busy, f_a, f_b, f_c, f_d, truth_table}, {1'b1, 1'b0, 4'hF, 16'h1234});

    // Abort at vector 6 with start also high.
    model = 16'hA5C3;
    expected = 16'hA5C3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while ({f_a, f_b, f_c, f_d} != 4'd6 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reach_v6", 32'(guard < 200), 32'd1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_idle", {busy, done, pass}, 32'h0);
    chk("abort_partial_tt", {16'h0, truth_table}, 32'h0003);
    @(posedge clk); #1;
    chk("abort_stays_idle", {busy, done}, 32'h0);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", {busy, done}, 32'h0);
    run_sweep(16'hA5C3, -1, edges, oerr);
    chk("rerun_edges", 32'(edges), 32'd80);
    chk("rerun_result", {order_err_zero(oerr), pass, truth_table}, {1'b1, 1'b1, 16'hA5C3});

    // Asynchronous reset at vector 9.
    model = 16'hA5C1 ^ 16'h0100;
    expected = 16'hA5C3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while ({f_a, f_b, f_c, f_d} != 4'd9 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rst_pre_mc", {27'h0, mismatch_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {f_a, f_b, f_c, f_d, busy, done, pass, truth_table, mismatch_cnt, first_fail_idx}, 32'h0);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_after", {f_a, f_b, f_c, f_d, busy, done}, 32'h0);

    // SETTLE_CYCLES=1 instance: 32-edge sweep, all-ones table.
    model1 = 16'hFFFF;
    expected1 = 16'hFFFF;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    edges = 0;
    oerr = 0;
    while (!done1 && edges < 500) begin
      if ({f_a1, f_b1, f_c1, f_d1} != 4'(edges / 2) || !busy1) oerr++;
      @(posedge clk); #1;
      edges++;
    end
    chk("s1_edges", 32'(edges), 32'd32);
    chk("s1_order", 32'(oerr), 32'd0);
    chk("s1_result", {pass1, mismatch_cnt1, truth_table1}, {1'b1, 5'd0, 16'hFFFF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic order_err_zero(input int e);
    return (e == 0);
  endfunction

endmodule
